// File: rtl/piezo_tone_decoder_pkg.sv
// Shared types and constants for the piezo tone decoder.
// Optional build macro TONE_TOL_EN is consumed by piezo_tone_decoder.sv.
package piezo_tone_decoder_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned SILENCE_MS = 50;

  // Cycles without an edge before the tone is declared gone.
  localparam int unsigned DEFAULT_SILENCE_LIMIT = (CLK_HZ / 1000) * SILENCE_MS;

  typedef enum logic [1:0] {
    StIdle,
    StWaitEdge,
    StMeasure
  } state_e;

endpackage

// File: rtl/piezo_tone_decoder_if.sv
// Control and result signals of the piezo tone decoder.
// master drives enable and the raw piezo input; slave is the decoder.
interface piezo_tone_decoder_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             i_en;
  logic             i_piezo;
  logic [CNT_W-1:0] o_cnt_limit;
  logic             o_valid;
  logic             o_tone_on;

  modport master (
    output i_en,
    output i_piezo,
    input  o_cnt_limit,
    input  o_valid,
    input  o_tone_on
  );

  modport slave (
    input  i_en,
    input  i_piezo,
    output o_cnt_limit,
    output o_valid,
    output o_tone_on
  );

endinterface

// File: rtl/piezo_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input plus a registered any-edge pulse.
// Reusable for any slow asynchronous level input.
module piezo_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

  assign any_edge = edge_q;

endmodule

// File: rtl/piezo_tone_decoder.sv
// Recovers a piezo generator's counter limit from the half-period of its square wave.
// Define TONE_TOL_EN to accept intervals within TOL cycles of each other as a match.
module piezo_tone_decoder
  import piezo_tone_decoder_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SILENCE_LIMIT = DEFAULT_SILENCE_LIMIT,
  parameter int unsigned STABLE_CNT    = 2
`ifdef TONE_TOL_EN
  ,
  parameter int unsigned TOL           = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  piezo_tone_decoder_if.slave  bus
);

  localparam int unsigned      MW        = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] SIL_MAX   = CNT_W'(SILENCE_LIMIT);
  localparam logic [CNT_W-1:0] SIL_HIT   = CNT_W'(SILENCE_LIMIT - 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(STABLE_CNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] icnt_q, icnt_d, icnt_inc;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [MW-1:0]    mcnt_q, mcnt_d, mcnt_hit;
  logic             valid_q, valid_d;
  logic             tone_q, tone_d;
  logic             any_edge;
  logic             close, match, report, silence;

  piezo_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (bus.i_piezo),
    .any_edge (any_edge)
  );

`ifdef TONE_TOL_EN
  logic [CNT_W-1:0] diff;
  always_comb begin
    diff  = (icnt_q >= last_q) ? (icnt_q - last_q) : (last_q - icnt_q);
    close = (diff <= CNT_W'(TOL));
  end
`else
  always_comb close = (icnt_q == last_q);
`endif

  // Measurement bookkeeping; icnt_q is the interval M on an edge cycle.
  always_comb begin
    icnt_inc = (icnt_q == SIL_MAX) ? icnt_q : icnt_q + CNT_W'(1);
    silence  = (state_q == StMeasure) && !any_edge && (icnt_inc == SIL_HIT);
    // The first interval after WAIT_EDGE has nothing valid to compare against.
    match    = close && (mcnt_q != '0);
    if (match) begin
      mcnt_hit = (mcnt_q == MATCH_MAX) ? mcnt_q : mcnt_q + MW'(1);
    end else begin
      mcnt_hit = MW'(1);
    end
    report   = (mcnt_hit == MATCH_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.i_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:     state_d = StWaitEdge;
        StWaitEdge: if (any_edge) state_d = StMeasure;
        StMeasure:  if (silence) state_d = StWaitEdge;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    icnt_d  = any_edge ? '0 : icnt_inc;
    last_d  = last_q;
    mcnt_d  = mcnt_q;
    limit_d = limit_q;
    valid_d = 1'b0;
    tone_d  = tone_q;
    if (!bus.i_en || (state_q == StIdle)) begin
      icnt_d = '0;
      mcnt_d = '0;
      tone_d = 1'b0;
    end else if (state_q == StMeasure) begin
      if (any_edge) begin
        mcnt_d = mcnt_hit;
        if (!match) begin
          last_d = icnt_q;
        end
        if (report) begin
          limit_d = icnt_q;
          valid_d = 1'b1;
          tone_d  = 1'b1;
        end
      end else if (silence) begin
        mcnt_d = '0;
        tone_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q  <= '0;
      last_q  <= '0;
      mcnt_q  <= '0;
      limit_q <= '0;
      valid_q <= 1'b0;
      tone_q  <= 1'b0;
    end else begin
      icnt_q  <= icnt_d;
      last_q  <= last_d;
      mcnt_q  <= mcnt_d;
      limit_q <= limit_d;
      valid_q <= valid_d;
      tone_q  <= tone_d;
    end
  end

  assign bus.o_cnt_limit = limit_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_tone_on   = tone_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Directed bench for piezo_tone_decoder: expected reports are queued as edges are
// driven and consumed by a monitor whenever o_valid pulses.
module tb_piezo_tone_decoder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];

`ifdef TONE_TOL_EN
  localparam logic [31:0] TOL_TONE = 32'd1;
`else
  localparam logic [31:0] TOL_TONE = 32'd0;
`endif

  piezo_tone_decoder_if #(.CNT_W(32)) bus ();

  piezo_tone_decoder #(
    .CNT_W         (32),
    .SYNC_STAGES   (2),
    .SILENCE_LIMIT (100),
    .STABLE_CNT    (2)
`ifdef TONE_TOL_EN
    ,
    .TOL           (2)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Flip the piezo input n rising edges after the previous flip.
  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk);
    #1 bus.i_piezo = ~bus.i_piezo;
  endtask

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("valid_limit", bus.o_cnt_limit, exp_q.pop_front());
        check("valid_tone", 32'(bus.o_tone_on), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.i_en    = 1'b0;
    bus.i_piezo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_limit", bus.o_cnt_limit, 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_tone", 32'(bus.o_tone_on), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 bus.i_en = 1'b1;

    // Steady tone, limit 9: third edge reports, then one report per edge.
    toggle_after(5);
    toggle_after(10);
    toggle_after(10);
    exp_q.push_back(32'd9);
    repeat (3) @(posedge clk);
    #1 check("lat_early", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_valid", 32'(bus.o_valid), 32'd1);
    check("lat_limit", bus.o_cnt_limit, 32'd9);
    toggle_after(6);
    exp_q.push_back(32'd9);
    toggle_after(10);
    exp_q.push_back(32'd9);
    toggle_after(10);
    exp_q.push_back(32'd9);

    // Silence: tone drops 100 cycles after the last edge is detected.
    repeat (102) @(posedge clk);
    #1 check("sil_before", 32'(bus.o_tone_on), 32'd1);
    @(posedge clk);
    #1 check("sil_after", 32'(bus.o_tone_on), 32'd0);
    check("sil_hold", bus.o_cnt_limit, 32'd9);
    check("drain_a", 32'(exp_q.size()), 32'd0);

    // Re-acquire at 9, then change to 24 mid-tone.
    toggle_after(20);
    toggle_after(10);
    toggle_after(10);
    exp_q.push_back(32'd9);
    toggle_after(25);
    repeat (5) @(posedge clk);
    #1 check("chg_tone", 32'(bus.o_tone_on), 32'd1);
    check("chg_limit", bus.o_cnt_limit, 32'd9);
    toggle_after(20);
    exp_q.push_back(32'd24);
    toggle_after(25);
    exp_q.push_back(32'd24);
    repeat (6) @(posedge clk);
    #1 check("drain_b", 32'(exp_q.size()), 32'd0);

    // One-cycle disable mid-tone.
    bus.i_en = 1'b0;
    @(posedge clk);
    #1 check("dis_tone", 32'(bus.o_tone_on), 32'd0);
    bus.i_en = 1'b1;
    toggle_after(10);
    toggle_after(25);
    repeat (5) @(posedge clk);
    #1 check("reen_tone", 32'(bus.o_tone_on), 32'd0);
    toggle_after(20);
    exp_q.push_back(32'd24);
    repeat (6) @(posedge clk);
    #1 check("drain_d", 32'(exp_q.size()), 32'd0);

    // Intervals 10, 11, 9 cycles: only reported with tolerance enabled.
    bus.i_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.i_en = 1'b1;
    toggle_after(5);
    toggle_after(10);
    toggle_after(11);
`ifdef TONE_TOL_EN
    exp_q.push_back(32'd10);
`endif
    toggle_after(9);
`ifdef TONE_TOL_EN
    exp_q.push_back(32'd8);
`endif
    repeat (6) @(posedge clk);
    #1 check("tol_tone", 32'(bus.o_tone_on), TOL_TONE);
    check("drain_e", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a measured tone.
    bus.i_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.i_en = 1'b1;
    toggle_after(5);
    toggle_after(10);
    toggle_after(10);
    exp_q.push_back(32'd9);
    repeat (6) @(posedge clk);
    #1 check("pre_rst_tone", 32'(bus.o_tone_on), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_limit", bus.o_cnt_limit, 32'd0);
    check("arst_valid", 32'(bus.o_valid), 32'd0);
    check("arst_tone", 32'(bus.o_tone_on), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("arst_valid_hold", 32'(bus.o_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("drain_f", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
